vga_image_ctrl: RTL
===================

VGA_IMAGE_CTRL -- requirements
Module: vga_image_ctrl

Interface
REQ-001 Parameter H_ACT_START, default 144, first active horizontal count.
REQ-002 Parameter V_ACT_START, default 35, first active vertical count.
REQ-003 Parameters IMG_W = 300 and IMG_H = 200, image window size in pixels.
REQ-004 Parameters H_TOTAL = 800 and V_TOTAL = 525, counter periods.
REQ-005 Parameter N_IMG, default 3, number of image ROMs.
REQ-006 Parameter SLIDE_FRAMES, default 120, frames per image in auto mode.
REQ-007 clk  in  1  pixel clock (25 MHz).
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 h_cnt, v_cnt  in  10 each  scan counters (h 0..799, v 0..524).
REQ-010 h_sync_in, v_sync_in  in  1 each  raw sync signals from the sync generator.
REQ-011 auto_en  in  1  slideshow mode enable; asynchronous source.
REQ-012 sel  in  2  manual image select; asynchronous source.
REQ-013 rom_data0..rom_data2  in  16 each  RGB565 data from the sync-read ROMs (1-clk latency).
REQ-014 rom_addr  out  16  shared ROM address.
REQ-015 rom_en  out  N_IMG  one-hot ROM enable.
REQ-016 R, G, B  out  4 each  pixel colour.
REQ-017 h_sync, v_sync  out  1 each  sync signals aligned to R/G/B.
REQ-018 cur_img  out  2  image currently displayed.
REQ-019 frame_start  out  1  one-clk pulse, registered, for the cycle after h_cnt==0 && v_cnt==0.

Function
REQ-020 The window is h in [H_ACT_START, H_ACT_START+IMG_W-1] and v in [V_ACT_START, V_ACT_START+IMG_H-1].
REQ-021 rom_addr is (v-V_ACT_START)*IMG_W + (h-H_ACT_START), built incrementally: column counter plus row base advanced by IMG_W per window line; no multiplier.
REQ-022 rom_addr is registered one clk after the counters; outside the window it is 0.
REQ-023 rom_en is onehot(cur_img) inside the window and 0 outside.
REQ-024 R/G/B for position (h,v) are registered 3 clk after the counters equal (h,v): R = data[15:12], G = data[10:7], B = data[4:1], taken from the ROM latched in cur_img.
REQ-025 Colour in the active area outside the window is F,F,F; colour during blanking (h < H_ACT_START or v < V_ACT_START) is 0,0,0.
REQ-026 h_sync and v_sync are h_sync_in and v_sync_in delayed 3 clk.
REQ-027 sel and auto_en each pass through a 2-flop synchronizer before use.
REQ-028 Switch FSM states: SHOW, PENDING, APPLY.
REQ-029 SHOW -> PENDING when the requested image differs from cur_img.
REQ-030 PENDING -> APPLY on a frame_start pulse; APPLY loads cur_img and returns to SHOW after 1 clk.
REQ-031 cur_img never changes outside APPLY, so a frame never mixes images.
REQ-032 In manual mode the request is synchronized sel; sel == 3 (or >= N_IMG) is ignored and the request holds.
REQ-033 In PENDING, a new request equal to cur_img returns the FSM to SHOW.
REQ-034 In auto mode, a frame counter counts frame_start pulses 0..SLIDE_FRAMES-1. At wrap the request becomes (cur_img+1) mod N_IMG. Manual sel is ignored.
REQ-035 Any edge of synchronized auto_en clears the frame counter.
REQ-036 In auto mode, the request resulting from a wrap is taken by the APPLY of the next frame_start, not the same one.
REQ-037 Counter values at or above H_TOTAL or V_TOTAL are treated as blanking.

Reset
REQ-038 Reset is asynchronous, active-low, and affects all flops.
REQ-039 Reset values: cur_img = 0; FSM = SHOW; frame counter = 0; rom_addr = 0; rom_en = 0.
REQ-040 Reset values: R, G, B = 0; h_sync, v_sync, frame_start = 0; pipeline valid bits = 0.
REQ-041 A reset mid-frame restarts address generation cleanly at the next window entry.

Structure
REQ-042 A shared package vga_pkg holds the timing constants (H_TOTAL, V_TOTAL, H_ACT_START, V_ACT_START), IMG_W, IMG_H, and the FSM state encoding.
REQ-043 One sub-module, vga_addr_gen, holds the window detect and the incremental address counters.

Verification
REQ-044 Reset, then counters at (144,35) -> rom_addr = 0 at +1 clk; R/G/B = rom_data0 fields at +3 clk.
REQ-045 Counters at (443,234) -> rom_addr = 59999; counters at (444,234) -> rom_addr = 0, and R/G/B = F,F,F at +3 clk.
REQ-046 sel 0->2 changed mid-window at v = 100 -> cur_img stays 0 until the next frame_start, then becomes 2; no pixel of that frame comes from ROM 2.
REQ-047 auto_en = 1, SLIDE_FRAMES = 2 -> cur_img sequence 0,1,2,0 with changes every 2 frames, only on frame_start.
REQ-048 sel = 3 -> cur_img unchanged; sel toggled 0->1->0 within one frame -> FSM returns to SHOW and cur_img stays 0.
REQ-049 rst asserted at (300,120) and released -> all outputs 0 during reset; first window pixel of the next frame has rom_addr = 0.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
//==============================================================================
// Module : vga_pkg
// Brief  : Shared VGA timing constants, image window size and the encoding of
//          the image-switch state machine.
// Rev    : 1.0  initial release
//==============================================================================
package vga_pkg;

   localparam int H_TOTAL     = 800;
   localparam int V_TOTAL     = 525;
   localparam int H_ACT_START = 144;
   localparam int V_ACT_START = 35;
   localparam int IMG_W       = 300;
   localparam int IMG_H       = 200;

   localparam logic [1:0] ST_SHOW    = 2'd0;
   localparam logic [1:0] ST_PENDING = 2'd1;
   localparam logic [1:0] ST_APPLY   = 2'd2;

   // Slideshow successor: wraps to image 0 after the last image
   function automatic logic [1:0] next_img(input logic [1:0] cur, input logic [1:0] last);
      return (cur == last) ? 2'd0 : cur + 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_addr_gen.sv
`default_nettype none
//==============================================================================
// Module : vga_addr_gen
// Brief  : Image window detect and incremental ROM address generation.
//          Address = row base + column; the row base steps by IMG_W at the
//          last column of each window line, so no multiplier is needed.
// Rev    : 1.0  initial release
//==============================================================================
module vga_addr_gen #(
   parameter int H_ACT_START = vga_pkg::H_ACT_START,
   parameter int V_ACT_START = vga_pkg::V_ACT_START,
   parameter int IMG_W       = vga_pkg::IMG_W,
   parameter int IMG_H       = vga_pkg::IMG_H,
   parameter int H_TOTAL     = vga_pkg::H_TOTAL,
   parameter int V_TOTAL     = vga_pkg::V_TOTAL
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  h_cnt_i,
   input  logic [9:0]  v_cnt_i,
   output logic        in_win_o,
   output logic        active_o,
   output logic [15:0] addr_o
);
   import vga_pkg::*;

   localparam logic [9:0]  H_WS    = 10'(H_ACT_START);
   localparam logic [9:0]  H_WE    = 10'(H_ACT_START + IMG_W - 1);
   localparam logic [9:0]  V_WS    = 10'(V_ACT_START);
   localparam logic [9:0]  V_WE    = 10'(V_ACT_START + IMG_H - 1);
   localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
   localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
   localparam logic [15:0] IMG_W16 = 16'(IMG_W);

   logic        w_h_win;
   logic        w_v_win;
   logic        w_last_col;
   logic [15:0] col_q, col_d;
   logic [15:0] row_q, row_d;
   logic [15:0] addr_q, addr_d;

   assign w_h_win    = (h_cnt_i >= H_WS) && (h_cnt_i <= H_WE);
   assign w_v_win    = (v_cnt_i >= V_WS) && (v_cnt_i <= V_WE);
   assign in_win_o   = w_h_win && w_v_win;
   assign w_last_col = in_win_o && (h_cnt_i == H_WE);
   // Counters past the period are treated as blanking
   assign active_o   = (h_cnt_i >= H_WS) && (v_cnt_i >= V_WS) &&
                       ({1'b0, h_cnt_i} < H_TOT) && ({1'b0, v_cnt_i} < V_TOT);
   assign addr_o     = addr_q;

   // Column restarts at every non-window cycle and after the last column;
   // row base is cleared whenever the scan is outside the window rows
   always_comb begin
      col_d  = 16'd0;
      row_d  = row_q;
      addr_d = 16'd0;
      if (in_win_o) begin
         addr_d = row_q + col_q;
         if (!w_last_col) begin
            col_d = col_q + 16'd1;
         end
      end
      if (!w_v_win) begin
         row_d = 16'd0;
      end else if (w_last_col) begin
         row_d = row_q + IMG_W16;
      end
   end

   // Address counter state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q  <= 16'd0;
         row_q  <= 16'd0;
         addr_q <= 16'd0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         addr_q <= addr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_image_ctrl.sv
`default_nettype none
//==============================================================================
// Module : vga_image_ctrl
// Brief  : Displays one of N_IMG ROM images in a fixed window, with manual
//          select or timed slideshow; image switches happen only at frame start.
// Rev    : 1.0  initial release
//==============================================================================
module vga_image_ctrl #(
   parameter int H_ACT_START  = vga_pkg::H_ACT_START,
   parameter int V_ACT_START  = vga_pkg::V_ACT_START,
   parameter int IMG_W        = vga_pkg::IMG_W,
   parameter int IMG_H        = vga_pkg::IMG_H,
   parameter int H_TOTAL      = vga_pkg::H_TOTAL,
   parameter int V_TOTAL      = vga_pkg::V_TOTAL,
   parameter int N_IMG        = 3,
   parameter int SLIDE_FRAMES = 120
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [9:0]       h_cnt,
   input  logic [9:0]       v_cnt,
   input  logic             h_sync_in,
   input  logic             v_sync_in,
   input  logic             auto_en,
   input  logic [1:0]       sel,
   input  logic [15:0]      rom_data0,
   input  logic [15:0]      rom_data1,
   input  logic [15:0]      rom_data2,
   output logic [15:0]      rom_addr,
   output logic [N_IMG-1:0] rom_en,
   output logic [3:0]       R,
   output logic [3:0]       G,
   output logic [3:0]       B,
   output logic             h_sync,
   output logic             v_sync,
   output logic [1:0]       cur_img,
   output logic             frame_start
);
   import vga_pkg::*;

   localparam int         FCW      = (SLIDE_FRAMES > 1) ? $clog2(SLIDE_FRAMES) : 1;
   localparam logic [FCW-1:0] FC_LAST = FCW'(SLIDE_FRAMES - 1);
   localparam logic [2:0] N_IMG_W  = 3'(N_IMG);
   localparam logic [1:0] IMG_LAST = 2'(N_IMG - 1);

   logic             w_in_win, w_active;
   logic [N_IMG-1:0] w_rom_en;
   logic [15:0]      w_pix;
   logic             w_unused;
   logic [11:0]      rgb_d, rgb_q;

   logic [1:0]     sel_s1_q, sel_s2_q;
   logic           auto_s1_q, auto_s2_q, auto_s3_q;
   logic           frame_start_q;
   logic [1:0]     req_q, req_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic [1:0]     state_q, state_d;
   logic [1:0]     cur_q, cur_d;
   logic [N_IMG-1:0] rom_en_q;
   logic           win1_q, act1_q, win2_q, act2_q;
   logic [1:0]     img1_q, img2_q;
   logic [2:0]     hs_q, vs_q;

   vga_addr_gen #(
      .H_ACT_START (H_ACT_START),
      .V_ACT_START (V_ACT_START),
      .IMG_W       (IMG_W),
      .IMG_H       (IMG_H),
      .H_TOTAL     (H_TOTAL),
      .V_TOTAL     (V_TOTAL)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .h_cnt_i  (h_cnt),
      .v_cnt_i  (v_cnt),
      .in_win_o (w_in_win),
      .active_o (w_active),
      .addr_o   (rom_addr)
   );

   for (genvar gi = 0; gi < N_IMG; gi++) begin : g_rom_en
      assign w_rom_en[gi] = w_in_win && (cur_q == 2'(gi));
   end

   // Input synchronizers and the registered frame-start strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_s1_q      <= 2'd0;
         sel_s2_q      <= 2'd0;
         auto_s1_q     <= 1'b0;
         auto_s2_q     <= 1'b0;
         auto_s3_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         sel_s1_q      <= sel;
         sel_s2_q      <= sel_s1_q;
         auto_s1_q     <= auto_en;
         auto_s2_q     <= auto_s1_q;
         auto_s3_q     <= auto_s2_q;
         frame_start_q <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      end
   end

   // Requested image: synchronized sel in manual mode, timed successor in auto mode
   always_comb begin
      req_d  = req_q;
      fcnt_d = fcnt_q;
      if (auto_s2_q != auto_s3_q) begin
         fcnt_d = '0;
      end else if (auto_s2_q && frame_start_q) begin
         if (fcnt_q == FC_LAST) begin
            fcnt_d = '0;
            req_d  = next_img(cur_q, IMG_LAST);
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
      if (!auto_s2_q && ({1'b0, sel_s2_q} < N_IMG_W)) begin
         req_d = sel_s2_q;
      end
   end

   // Switch FSM: a change waits for a frame start, so a frame never mixes images
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      case (state_q)
         ST_SHOW: begin
            if (req_q != cur_q) state_d = ST_PENDING;
         end
         ST_PENDING: begin
            if (req_q == cur_q)     state_d = ST_SHOW;
            else if (frame_start_q) state_d = ST_APPLY;
         end
         ST_APPLY: begin
            cur_d   = req_q;
            state_d = ST_SHOW;
         end
         default: state_d = ST_SHOW;
      endcase
   end

   // Request, frame counter and FSM state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q   <= 2'd0;
         fcnt_q  <= '0;
         state_q <= ST_SHOW;
         cur_q   <= 2'd0;
      end else begin
         req_q   <= req_d;
         fcnt_q  <= fcnt_d;
         state_q <= state_d;
         cur_q   <= cur_d;
      end
   end

   // Pixel pipeline: region and image travel alongside the ROM read latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rom_en_q <= '0;
         win1_q   <= 1'b0;
         act1_q   <= 1'b0;
         img1_q   <= 2'd0;
         win2_q   <= 1'b0;
         act2_q   <= 1'b0;
         img2_q   <= 2'd0;
         hs_q     <= 3'd0;
         vs_q     <= 3'd0;
      end else begin
         rom_en_q <= w_rom_en;
         win1_q   <= w_in_win;
         act1_q   <= w_active;
         img1_q   <= cur_q;
         win2_q   <= win1_q;
         act2_q   <= act1_q;
         img2_q   <= img1_q;
         hs_q     <= {hs_q[1:0], h_sync_in};
         vs_q     <= {vs_q[1:0], v_sync_in};
      end
   end

   // Select the ROM that was enabled for this pixel
   always_comb begin
      case (img2_q)
         2'd0:    w_pix = rom_data0;
         2'd1:    w_pix = rom_data1;
         default: w_pix = rom_data2;
      endcase
   end

   assign w_unused = ^{w_pix[11], w_pix[6:5], w_pix[0]};

   // RGB565 to 4:4:4 inside the window, white in the rest of the active area
   always_comb begin
      rgb_d = 12'h000;
      if (win2_q) begin
         rgb_d = {w_pix[15:12], w_pix[10:7], w_pix[4:1]};
      end else if (act2_q) begin
         rgb_d = 12'hFFF;
      end
   end

   // Colour output register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rgb_q <= 12'h000;
      else      rgb_q <= rgb_d;
   end

   assign rom_en      = rom_en_q;
   assign R           = rgb_q[11:8];
   assign G           = rgb_q[7:4];
   assign B           = rgb_q[3:0];
   assign h_sync      = hs_q[2];
   assign v_sync      = vs_q[2];
   assign cur_img     = cur_q;
   assign frame_start = frame_start_q;

endmodule
`default_nettype wire
